// File: rtl/result_formatter.sv
// result_formatter: converts an 11-bit two's-complement result into a sign code
// plus four BCD digit codes and streams them out with a valid/ready handshake.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for sel; captures sign and magnitude on start
// CONV  | 11 double-dabble iterations (add-3 then shift), one per cycle
// EMIT  | presents sign, thousands, hundreds, tens, units codes in order
module result_formatter (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic [10:0] data_in,
  input  logic        digit_ready,
  output logic [10:0] digit_out,
  output logic        digit_valid,
  output logic        digit_last,
  output logic        busy,
  output logic        done,
  output logic        sign,
  output logic [15:0] bcd
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    EMIT = 2'd2
  } state_t;

  localparam logic [10:0] CODE_PLUS  = 11'd10;
  localparam logic [10:0] CODE_MINUS = 11'd11;

  state_t      state;
  state_t      state_nxt;
  logic [10:0] mag_sr;
  logic [15:0] bcd_sr;
  logic        neg_r;
  logic [3:0]  iter_cnt;
  logic [2:0]  emit_idx;

  logic        start;
  logic        conv_last;
  logic        xfer;
  logic        emit_end;
  logic [15:0] bcd_adj;
  logic [15:0] bcd_shift;

  // Code presented for a given emit position, taken from the loaded outputs.
  function automatic logic [10:0] code_of(input logic [2:0] idx,
                                          input logic s,
                                          input logic [15:0] b);
    logic [10:0] c;
    case (idx)
      3'd0:    c = s ? CODE_MINUS : CODE_PLUS;
      3'd1:    c = {7'd0, b[15:12]};
      3'd2:    c = {7'd0, b[11:8]};
      3'd3:    c = {7'd0, b[7:4]};
      3'd4:    c = {7'd0, b[3:0]};
      default: c = 11'd0;
    endcase
    return c;
  endfunction

  // Double-dabble step: add 3 to every nibble >= 5, then shift in the next magnitude bit.
  always_comb begin
    bcd_adj = bcd_sr;
    for (int i = 0; i < 4; i++) begin
      if (bcd_sr[i*4 +: 4] >= 4'd5) begin
        bcd_adj[i*4 +: 4] = bcd_sr[i*4 +: 4] + 4'd3;
      end
    end
    bcd_shift = {bcd_adj[14:0], mag_sr[10]};
  end

  // Control strobes and next-state decode.
  always_comb begin
    // A start in the done cycle is dropped: the stream has only just ended.
    start     = (state == IDLE) && sel && !done;
    conv_last = (state == CONV) && (iter_cnt == 4'd10);
    xfer      = (state == EMIT) && digit_valid && digit_ready;
    emit_end  = xfer && digit_last;
    state_nxt = state;
    case (state)
      IDLE:    if (start)     state_nxt = CONV;
      CONV:    if (conv_last) state_nxt = EMIT;
      EMIT:    if (emit_end)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath: capture, conversion shift registers, output handshake registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mag_sr      <= '0;
      bcd_sr      <= '0;
      neg_r       <= 1'b0;
      iter_cnt    <= '0;
      emit_idx    <= '0;
      digit_out   <= '0;
      digit_valid <= 1'b0;
      digit_last  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      sign        <= 1'b0;
      bcd         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            neg_r    <= data_in[10];
            // -1024 negates to 11'h400, which reads as 1024 unsigned.
            mag_sr   <= data_in[10] ? (~data_in + 11'd1) : data_in;
            bcd_sr   <= '0;
            iter_cnt <= '0;
            busy     <= 1'b1;
          end
        end
        CONV: begin
          bcd_sr   <= bcd_shift;
          mag_sr   <= {mag_sr[9:0], 1'b0};
          iter_cnt <= iter_cnt + 4'd1;
          if (iter_cnt == 4'd10) begin
            bcd      <= bcd_shift;
            sign     <= neg_r;
            emit_idx <= '0;
            iter_cnt <= '0;
          end
        end
        EMIT: begin
          if (!digit_valid) begin
            digit_valid <= 1'b1;
            digit_out   <= code_of(emit_idx, sign, bcd);
            digit_last  <= (emit_idx == 3'd4);
          end else if (digit_ready) begin
            if (digit_last) begin
              digit_valid <= 1'b0;
              digit_last  <= 1'b0;
              busy        <= 1'b0;
              done        <= 1'b1;
              emit_idx    <= '0;
            end else begin
              emit_idx   <= emit_idx + 3'd1;
              digit_out  <= code_of(emit_idx + 3'd1, sign, bcd);
              digit_last <= (emit_idx == 3'd3);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_result_formatter.sv
// Testbench for result_formatter: expected codes are queued when a conversion
// is started and popped as each code transfers on the handshake.
module tb_result_formatter;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic [10:0] data_in;
  logic        digit_ready;
  logic [10:0] digit_out;
  logic        digit_valid;
  logic        digit_last;
  logic        busy;
  logic        done;
  logic        sign;
  logic [15:0] bcd;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [10:0] exp_q[$];
  logic [15:0] exp_bcd;
  logic        exp_sign;

  result_formatter dut (
    .clk         (clk),
    .rst         (rst),
    .sel         (sel),
    .data_in     (data_in),
    .digit_ready (digit_ready),
    .digit_out   (digit_out),
    .digit_valid (digit_valid),
    .digit_last  (digit_last),
    .busy        (busy),
    .done        (done),
    .sign        (sign),
    .bcd         (bcd)
  );

  always #5 clk = ~clk;

  // Reference model: decimal digits of the magnitude, queued as codes.
  task automatic model_push(input logic [10:0] v);
    int m;
    m = v[10] ? (2048 - int'(v)) : int'(v);
    exp_q.push_back(v[10] ? 11'd11 : 11'd10);
    exp_q.push_back(11'(m / 1000));
    exp_q.push_back(11'((m / 100) % 10));
    exp_q.push_back(11'((m / 10) % 10));
    exp_q.push_back(11'(m % 10));
    exp_bcd  = {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
    exp_sign = v[10];
  endtask

  task automatic start_conv(input logic [10:0] v);
    model_push(v);
    @(negedge clk);
    sel     = 1'b1;
    data_in = v;
    @(negedge clk);
    sel     = 1'b0;
    data_in = '0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_after_start: got %b expected 1", busy);
    end
  endtask

  // Runs the handshake until done; optional stall and stray sel pulses.
  task automatic drain(input int stall_idx, input int stall_len, input int sel_at,
                       input bit sel_on_done, output int done_cyc,
                       output int first_v, output int n_xfer);
    int          k;
    int          stalled;
    logic [10:0] e;
    k = 0; stalled = 0;
    done_cyc = -1; first_v = -1; n_xfer = 0;
    digit_ready = 1'b1;
    while (k < 100 && done_cyc < 0) begin
      @(negedge clk);
      k++;
      sel = 1'b0;
      if (k == sel_at) begin
        sel     = 1'b1;
        data_in = 11'd9;
      end
      if (digit_valid && first_v < 0) first_v = k;
      if (done) begin
        done_cyc = k;
        if (sel_on_done) begin
          sel     = 1'b1;
          data_in = 11'd9;
        end
      end
      if (digit_valid && n_xfer == stall_idx && stalled < stall_len) begin
        digit_ready = 1'b0;
        stalled++;
        n_checks++;
        if (exp_q.size() == 0 || digit_out !== exp_q[0]) begin
          n_fail++;
          $display("FAIL stall_hold: got %0d expected %0d", digit_out,
                   (exp_q.size() == 0) ? 0 : int'(exp_q[0]));
        end
      end else begin
        digit_ready = 1'b1;
      end
      if (digit_valid && digit_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL extra_code: got %0d expected no code", digit_out);
        end else begin
          e = exp_q.pop_front();
          if (digit_out !== e) begin
            n_fail++;
            $display("FAIL code[%0d]: got %0d expected %0d", n_xfer, digit_out, e);
          end
          n_checks++;
          if (digit_last !== (exp_q.size() == 0)) begin
            n_fail++;
            $display("FAIL last[%0d]: got %b expected %b", n_xfer, digit_last,
                     exp_q.size() == 0);
          end
        end
        n_xfer++;
      end
    end
    @(negedge clk);
    sel     = 1'b0;
    data_in = '0;
    n_checks++;
    if (done_cyc < 0) begin
      n_fail++;
      $display("FAIL done_timeout: got no done expected done within 100 cycles");
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_codes: got %0d left expected 0", exp_q.size());
    end
    n_checks++;
    if ({done, busy, digit_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL after_done: got done/busy/valid=%b expected 000",
               {done, busy, digit_valid});
    end
  endtask

  task automatic check_result(input string name);
    n_checks++;
    if (bcd !== exp_bcd || sign !== exp_sign) begin
      n_fail++;
      $display("FAIL %s_result: got bcd=%h sign=%b expected bcd=%h sign=%b",
               name, bcd, sign, exp_bcd, exp_sign);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    n_checks++;
    if ({digit_out, digit_valid, digit_last, busy, done, sign, bcd} !== 33'd0) begin
      n_fail++;
      $display("FAIL %s: got out=%0d v=%b l=%b busy=%b done=%b sign=%b bcd=%h expected all 0",
               name, digit_out, digit_valid, digit_last, busy, done, sign, bcd);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; sel = 1'b0; data_in = '0; digit_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int dc, fv, nx;
    start_conv(11'd123);
    drain(-1, 0, -1, 1'b0, dc, fv, nx);
    n_checks++;
    if (fv !== 12) begin
      n_fail++;
      $display("FAIL first_valid_cycle: got %0d expected 12", fv);
    end
    n_checks++;
    if (dc !== 17) begin
      n_fail++;
      $display("FAIL done_cycle: got %0d expected 17", dc);
    end
    n_checks++;
    if (nx !== 5) begin
      n_fail++;
      $display("FAIL transfer_count: got %0d expected 5", nx);
    end
    check_result("basic");
  endtask

  task automatic test_values();
    logic [10:0] vals[4];
    int dc, fv, nx;
    vals = '{11'h400, 11'h7FF, 11'd1023, 11'd0};
    for (int i = 0; i < 4; i++) begin
      start_conv(vals[i]);
      drain(-1, 0, -1, 1'b0, dc, fv, nx);
      n_checks++;
      if (dc !== 17 || nx !== 5) begin
        n_fail++;
        $display("FAIL value_%h_timing: got done=%0d xfers=%0d expected 17 and 5",
                 vals[i], dc, nx);
      end
      check_result("value");
    end
  endtask

  task automatic test_backpressure();
    int dc, fv, nx;
    start_conv(11'd57);
    drain(2, 3, -1, 1'b0, dc, fv, nx);
    n_checks++;
    if (dc !== 20 || nx !== 5) begin
      n_fail++;
      $display("FAIL backpressure_timing: got done=%0d xfers=%0d expected 20 and 5", dc, nx);
    end
    check_result("backpressure");
  endtask

  task automatic test_sel_ignored();
    int dc, fv, nx;
    bit stray;
    start_conv(11'd123);
    drain(-1, 0, 3, 1'b1, dc, fv, nx);
    n_checks++;
    if (dc !== 17 || nx !== 5) begin
      n_fail++;
      $display("FAIL sel_ignored_timing: got done=%0d xfers=%0d expected 17 and 5", dc, nx);
    end
    stray = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (busy || digit_valid) stray = 1'b1;
    end
    n_checks++;
    if (stray) begin
      n_fail++;
      $display("FAIL sel_ignored_restart: got activity expected idle");
    end
    check_result("sel_ignored");
  endtask

  task automatic test_reset_mid();
    int  dc, fv, nx, cnt, k;
    bit  stray;
    start_conv(11'd999);
    exp_q.delete();
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset_in_conv");
    rst = 1'b0;
    stray = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (busy || digit_valid) stray = 1'b1;
    end
    n_checks++;
    if (stray) begin
      n_fail++;
      $display("FAIL conv_resumed: got activity expected idle");
    end

    start_conv(11'h6BF);
    exp_q.delete();
    digit_ready = 1'b1;
    cnt = 0; k = 0;
    while (cnt < 2 && k < 40) begin
      @(negedge clk);
      k++;
      if (digit_valid && digit_ready) cnt++;
    end
    n_checks++;
    if (cnt !== 2) begin
      n_fail++;
      $display("FAIL emit_timeout: got %0d codes expected 2", cnt);
    end
    @(negedge clk);
    rst = 1'b1;
    digit_ready = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset_in_emit");
    rst = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (busy || digit_valid) begin
      n_fail++;
      $display("FAIL emit_resumed: got busy=%b valid=%b expected 0 0", busy, digit_valid);
    end

    start_conv(11'd42);
    drain(-1, 0, -1, 1'b0, dc, fv, nx);
    n_checks++;
    if (dc !== 17 || nx !== 5) begin
      n_fail++;
      $display("FAIL fresh_start_timing: got done=%0d xfers=%0d expected 17 and 5", dc, nx);
    end
    check_result("fresh_start");
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; data_in = '0; digit_ready = 1'b0;
    test_reset();
    test_basic();
    test_values();
    test_backpressure();
    test_sel_ignored();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
